lms_fir_core: RTL and testbench
===============================

LMS_FIR_CORE -- requirements
Module: lms_fir_core

Interface
REQ-001 Parameter: FRAC, 10, fractional bits of Q-format data; product right-shift amount; legal range 0..13.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rstn  in  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  in  1  new sample pair offered on x_in/d_in.
REQ-005 Port: in_ready  out  1  block in IDLE; sample accepted on the edge where in_valid & in_ready.
REQ-006 Port: x_in  in  14  reference sample, two's complement.
REQ-007 Port: d_in  in  14  desired sample, two's complement.
REQ-008 Port: weight_in_0 .. weight_in_15  in  14 each  tap weights from the weight-update block, two's complement.
REQ-009 Port: reff_0 .. reff_15  out  14 each  tap delay line; reff_0 newest sample.
REQ-010 Port: y_out  out  14  filter output, registered.
REQ-011 Port: e  out  14  error d - y, registered.
REQ-012 Port: out_valid  out  1  one-cycle pulse; y_out/e updated.
REQ-013 Port: weight_cal_state  out  1  one-cycle pulse commanding the weight-update block to apply one update.

Function
REQ-014 FSM states IDLE, MAC, ERR, UPD; in_ready = (state == IDLE).
REQ-015 IDLE: on accept, reff_k <= reff_(k-1) for k=1..15, reff_0 <= x_in, d_in captured, accumulator cleared, tap index cleared, go to MAC.
REQ-016 MAC: 16 cycles, tap index 0..15; acc <= acc + weight_in_idx * reff_idx as signed 28-bit product sign-extended into a 32-bit signed accumulator; after index 15 go to ERR.
REQ-017 ERR: y = acc >>> FRAC (arithmetic), reduced to 14 bits per REQ-026; e = d - y computed at 15 bits, reduced to 14 bits per REQ-026; both registered; go to UPD.
REQ-018 UPD: out_valid = 1 and weight_cal_state = 1 for exactly this cycle; return to IDLE.
REQ-019 Latency: out_valid high in the 18th cycle after the accepting edge; throughput one sample per 19 cycles.
REQ-020 reff_0..15 change only on an accept edge; stable through MAC, ERR, and UPD, so the update block sees taps matching e.
REQ-021 weight_in_* sampled during MAC only; changes outside MAC have no effect on the current sample.
REQ-022 in_valid while in_ready = 0 is ignored; the sample is dropped, with no queueing and no state change.
REQ-023 y_out and e hold their last values between out_valid pulses.

Reset
REQ-024 rstn low, at any time including mid-MAC: state = IDLE; reff_*, y_out, e, accumulator, tap index, and captured d = 0; out_valid = 0; weight_cal_state = 0; in_ready = 1 while in reset and after release.
REQ-025 First accept possible on the first rising edge after rstn deasserts.

Configuration
REQ-026 Macro FIR_SAT_EN: defined -> y and e saturate to [-8192, 8191]; undefined -> y and e are the low 14 bits of the two's-complement result (wrap).

Verification
REQ-027 Reset check: assert rstn = 0 -> all outputs 0, in_ready = 1, out_valid = 0.
REQ-028 Zero weights, x = 1024, d = 512 -> out_valid exactly 18 cycles after accept, y_out = 0, e = 512, weight_cal_state pulses once with out_valid.
REQ-029 Identity filter: weight_in_0 = 1024, others 0; x = 300, d = 300 -> reff_0 = 300, y_out = 300, e = 0.
REQ-030 Delay line: samples 1, 2, 3, 4 in sequence -> reff_0 = 4, reff_3 = 1, reff_4..15 = 0; assert in_valid mid-MAC -> that sample is ignored and reff is unchanged.
REQ-031 Overflow: all weights = 8191, 16 samples of 8191, d = 0 -> with FIR_SAT_EN: y_out = 8191, e = -8191; without: y_out = -256, e = 256.
REQ-032 Reset mid-MAC: drop rstn at MAC index 7 -> immediate clear; no out_valid; in_ready = 1; the next sample processes normally.

Source files
------------

// File: rtl/lms_fir_core.sv
// 16-tap LMS FIR datapath: tap delay line, serial MAC, error and weight-update strobe.
// Define FIR_SAT_EN to saturate y and e to 14 bits; otherwise they wrap.
module lms_fir_core #(
    parameter int FRAC = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] x_in,
    input  logic [13:0] d_in,
    input  logic [13:0] weight_in_0,
    input  logic [13:0] weight_in_1,
    input  logic [13:0] weight_in_2,
    input  logic [13:0] weight_in_3,
    input  logic [13:0] weight_in_4,
    input  logic [13:0] weight_in_5,
    input  logic [13:0] weight_in_6,
    input  logic [13:0] weight_in_7,
    input  logic [13:0] weight_in_8,
    input  logic [13:0] weight_in_9,
    input  logic [13:0] weight_in_10,
    input  logic [13:0] weight_in_11,
    input  logic [13:0] weight_in_12,
    input  logic [13:0] weight_in_13,
    input  logic [13:0] weight_in_14,
    input  logic [13:0] weight_in_15,
    output logic [13:0] reff_0,
    output logic [13:0] reff_1,
    output logic [13:0] reff_2,
    output logic [13:0] reff_3,
    output logic [13:0] reff_4,
    output logic [13:0] reff_5,
    output logic [13:0] reff_6,
    output logic [13:0] reff_7,
    output logic [13:0] reff_8,
    output logic [13:0] reff_9,
    output logic [13:0] reff_10,
    output logic [13:0] reff_11,
    output logic [13:0] reff_12,
    output logic [13:0] reff_13,
    output logic [13:0] reff_14,
    output logic [13:0] reff_15,
    output logic [13:0] y_out,
    output logic [13:0] e,
    output logic        out_valid,
    output logic        weight_cal_state
);

    typedef enum logic [1:0] {StIdle, StMac, StErr, StUpd} state_t;

    state_t                state_q, state_d;
    logic signed [13:0]    reff_q [16];
    logic signed [13:0]    w [16];
    logic signed [31:0]    acc_q;
    logic        [3:0]     idx_q;
    logic        [13:0]    d_q, y_q, e_q;
    logic        [13:0]    y_d, e_d;
    logic signed [13:0]    w_sel, r_sel;
    logic signed [27:0]    prod;

    assign w[0]  = weight_in_0;   assign w[1]  = weight_in_1;
    assign w[2]  = weight_in_2;   assign w[3]  = weight_in_3;
    assign w[4]  = weight_in_4;   assign w[5]  = weight_in_5;
    assign w[6]  = weight_in_6;   assign w[7]  = weight_in_7;
    assign w[8]  = weight_in_8;   assign w[9]  = weight_in_9;
    assign w[10] = weight_in_10;  assign w[11] = weight_in_11;
    assign w[12] = weight_in_12;  assign w[13] = weight_in_13;
    assign w[14] = weight_in_14;  assign w[15] = weight_in_15;

    assign reff_0  = reff_q[0];   assign reff_1  = reff_q[1];
    assign reff_2  = reff_q[2];   assign reff_3  = reff_q[3];
    assign reff_4  = reff_q[4];   assign reff_5  = reff_q[5];
    assign reff_6  = reff_q[6];   assign reff_7  = reff_q[7];
    assign reff_8  = reff_q[8];   assign reff_9  = reff_q[9];
    assign reff_10 = reff_q[10];  assign reff_11 = reff_q[11];
    assign reff_12 = reff_q[12];  assign reff_13 = reff_q[13];
    assign reff_14 = reff_q[14];  assign reff_15 = reff_q[15];

    assign in_ready         = (state_q == StIdle);
    assign out_valid        = (state_q == StUpd);
    assign weight_cal_state = (state_q == StUpd);
    assign y_out            = y_q;
    assign e                = e_q;

    always_comb begin
        w_sel = w[idx_q];
        r_sel = reff_q[idx_q];
        prod  = 28'(w_sel) * 28'(r_sel);
    end

`ifdef FIR_SAT_EN
    logic signed [31:0] acc_sh;
    logic signed [14:0] e_wide;

    always_comb begin
        acc_sh = acc_q >>> FRAC;
        if (acc_sh > 32'sd8191) begin
            y_d = 14'h1fff;
        end else if (acc_sh < -32'sd8192) begin
            y_d = 14'h2000;
        end else begin
            y_d = acc_sh[13:0];
        end
        // y is reduced before the subtraction so e matches the y the user sees
        e_wide = {d_q[13], d_q} - {y_d[13], y_d};
        if (e_wide > 15'sd8191) begin
            e_d = 14'h1fff;
        end else if (e_wide < -15'sd8192) begin
            e_d = 14'h2000;
        end else begin
            e_d = e_wide[13:0];
        end
    end
`else
    always_comb begin
        y_d = 14'(acc_q >>> FRAC);
        e_d = d_q - y_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (idx_q == 4'd15) state_d = StErr;
            StErr:   state_d = StUpd;
            StUpd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            for (int k = 0; k < 16; k++) reff_q[k] <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            d_q     <= '0;
            y_q     <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int k = 15; k > 0; k--) reff_q[k] <= reff_q[k-1];
                        reff_q[0] <= x_in;
                        d_q       <= d_in;
                        acc_q     <= '0;
                        idx_q     <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + 32'(prod);
                    idx_q <= idx_q + 4'd1;
                end
                StErr: begin
                    y_q <= y_d;
                    e_q <= e_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_fir_core.sv
// Self-checking bench for lms_fir_core: behavioural model feeds a scoreboard queue,
// directed steps cover reset, latency, delay line, overflow and mid-MAC reset.
module tb_lms_fir_core;

    localparam int FRAC = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] x_in = '0;
    logic [13:0] d_in = '0;
    logic        in_ready, out_valid, wcs;
    logic [13:0] y_out, e_o;
    logic [13:0] w [16];
    logic [13:0] reff [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int y;
        int e;
    } exp_t;
    exp_t sb[$];
    int   m_taps[16];

    always #5 clk = ~clk;

    lms_fir_core #(.FRAC(FRAC)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .d_in(d_in),
        .weight_in_0(w[0]),   .weight_in_1(w[1]),   .weight_in_2(w[2]),   .weight_in_3(w[3]),
        .weight_in_4(w[4]),   .weight_in_5(w[5]),   .weight_in_6(w[6]),   .weight_in_7(w[7]),
        .weight_in_8(w[8]),   .weight_in_9(w[9]),   .weight_in_10(w[10]), .weight_in_11(w[11]),
        .weight_in_12(w[12]), .weight_in_13(w[13]), .weight_in_14(w[14]), .weight_in_15(w[15]),
        .reff_0(reff[0]),     .reff_1(reff[1]),     .reff_2(reff[2]),     .reff_3(reff[3]),
        .reff_4(reff[4]),     .reff_5(reff[5]),     .reff_6(reff[6]),     .reff_7(reff[7]),
        .reff_8(reff[8]),     .reff_9(reff[9]),     .reff_10(reff[10]),   .reff_11(reff[11]),
        .reff_12(reff[12]),   .reff_13(reff[13]),   .reff_14(reff[14]),   .reff_15(reff[15]),
        .y_out(y_out), .e(e_o), .out_valid(out_valid), .weight_cal_state(wcs)
    );

    function automatic int s14(logic [13:0] v);
        return int'($signed(v));
    endfunction

    function automatic int reduce14(int v);
        int r;
`ifdef FIR_SAT_EN
        r = (v > 8191) ? 8191 : (v < -8192) ? -8192 : v;
`else
        r = v & 16383;
        if (r >= 8192) r = r - 16384;
`endif
        return r;
    endfunction

    task automatic check(string tag, int got, int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Model step taken at the accepting edge; weights are held constant across a sample.
    task automatic model_accept(int x, int d);
        longint s = 0;
        int     acc, ys, es;
        for (int k = 15; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = x;
        for (int k = 0; k < 16; k++) s += longint'(s14(w[k])) * longint'(m_taps[k]);
        acc = int'(s);
        ys  = reduce14(acc >>> FRAC);
        es  = reduce14(d - ys);
        sb.push_back('{y: ys, e: es});
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) m_taps[k] = 0;
        sb.delete();
    endtask

    task automatic send(int x, int d);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        x_in     = 14'(x);
        d_in     = 14'(d);
        in_valid = 1'b1;
        @(posedge clk);
        model_accept(x, d);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(string tag, int start);
        int   n   = start;
        bit   got = 1'b0;
        exp_t ex;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) got = 1'b1;
        end
        check({tag, "_valid"}, int'(got), 1);
        if (sb.size() > 0) ex = sb.pop_front();
        else ex = '{y: 0, e: 0};
        if (got) begin
            check({tag, "_lat"}, n, 18);
            check({tag, "_wcs"}, int'(wcs), 1);
            check({tag, "_y"}, s14(y_out), ex.y);
            check({tag, "_e"}, s14(e_o), ex.e);
            @(negedge clk);
            check({tag, "_pulse"}, int'(out_valid | wcs), 0);
            check({tag, "_yhold"}, s14(y_out), ex.y);
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int k = 0; k < 16; k++) w[k] = '0;
        clear_model();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_y", s14(y_out), 0);
        check("rst_e", s14(e_o), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_wcs", int'(wcs), 0);
        check("rst_reff0", s14(reff[0]), 0);
        check("rst_reff15", s14(reff[15]), 0);

        // First accept on the first edge after release; zero weights
        rstn = 1'b1;
        send(1024, 512);
        check("first_accept", int'(in_ready), 0);
        wait_out("zero", 0);
        check("zero_y_const", s14(y_out), 0);
        check("zero_e_const", s14(e_o), 512);

        // Identity filter
        w[0] = 14'd1024;
        send(300, 300);
        wait_out("ident", 0);
        check("ident_reff0", s14(reff[0]), 300);
        check("ident_y_const", s14(y_out), 300);
        check("ident_e_const", s14(e_o), 0);

        // Delay line with mixed weights, plus a dropped sample mid-MAC
        pulse_reset();
        for (int k = 0; k < 16; k++) w[k] = 14'(k * 53 - 300);
        for (int i = 1; i <= 3; i++) begin
            send(i, 10 * i);
            wait_out("dly", 0);
        end
        send(4, -7);
        repeat (5) @(posedge clk);
        #1;
        x_in     = 14'd99;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("dly4", 6);
        for (int k = 0; k < 4; k++) check($sformatf("dly_reff%0d", k), s14(reff[k]), 4 - k);
        for (int k = 4; k < 16; k++) check($sformatf("dly_reff%0d", k), s14(reff[k]), 0);

        // Overflow: full-scale weights and samples
        pulse_reset();
        for (int k = 0; k < 16; k++) w[k] = 14'h1fff;
        for (int i = 0; i < 16; i++) begin
            send(8191, 0);
            wait_out("ovf", 0);
        end
`ifdef FIR_SAT_EN
        check("ovf_y_const", s14(y_out), 8191);
        check("ovf_e_const", s14(e_o), -8191);
`else
        check("ovf_y_const", s14(y_out), -256);
        check("ovf_e_const", s14(e_o), 256);
`endif

        // Reset at MAC index 7
        pulse_reset();
        send(100, 50);
        repeat (7) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        clear_model();
        check("mrst_ready", int'(in_ready), 1);
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_y", s14(y_out), 0);
        check("mrst_e", s14(e_o), 0);
        check("mrst_reff0", s14(reff[0]), 0);
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("mrst_no_valid", cnt, 0);
        send(100, 50);
        wait_out("post_rst", 0);
        check("post_rst_y_const", s14(y_out), 799);
        check("post_rst_e_const", s14(e_o), -749);

        // Random weights and samples
        pulse_reset();
        for (int k = 0; k < 16; k++) w[k] = 14'(int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < 6; i++) begin
            send(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
            wait_out("rand", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
